// File: rtl/t05_sd_sched.sv
`default_nettype none
// t05_sd_sched (rev 1.0): tick-paced scheduler/arbiter between block clients and the t05_SPI SD engine.
// Optional: define T05_SD_SCHED_TIMEOUT_EN to add a 64-tick WR_END timeout reported on err.
module t05_sd_sched #(
  parameter int SCLK_DIV    = 4,
  parameter int BLOCK_BYTES = 512,
  parameter int INIT_TICKS  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        rd_last,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic        wr_done,
`ifdef T05_SD_SCHED_TIMEOUT_EN
  output logic        err,
`endif
  output logic        busy,
  output logic        spi_serial_clk,
  output logic        spi_read_en,
  output logic        spi_write_en,
  output logic        spi_read_stop,
  output logic [31:0] spi_read_address,
  output logic [31:0] spi_write_address,
  output logic        spi_writebit,
  input  logic [7:0]  spi_read_output,
  input  logic        spi_finish
);

  localparam int DW = $clog2(SCLK_DIV);
  localparam int CW = $clog2(BLOCK_BYTES * 8) + 1;
  localparam int TW = ($clog2(INIT_TICKS) > 6) ? $clog2(INIT_TICKS) : 6;

  localparam logic [3:0] c_ST_INIT   = 4'd0;
  localparam logic [3:0] c_ST_IDLE   = 4'd1;
  localparam logic [3:0] c_ST_RDCMD  = 4'd2;
  localparam logic [3:0] c_ST_RDSTRM = 4'd3;
  localparam logic [3:0] c_ST_RDSTOP = 4'd4;
  localparam logic [3:0] c_ST_WRSW   = 4'd5;
  localparam logic [3:0] c_ST_WRCMD  = 4'd6;
  localparam logic [3:0] c_ST_WRBITS = 4'd7;
  localparam logic [3:0] c_ST_WREND  = 4'd8;
  localparam logic [3:0] c_ST_LOCKED = 4'd9;

  localparam logic [DW-1:0] c_DIV_LAST  = DW'(SCLK_DIV - 1);
  localparam logic [TW-1:0] c_INIT_LAST = TW'(INIT_TICKS - 1);
  localparam logic [TW-1:0] c_CMD_LAST  = TW'(47);
  localparam logic [TW-1:0] c_SLOT_PRE  = TW'(7);
  localparam logic [TW-1:0] c_SLOT_LAST = TW'(8);
  localparam logic [CW-1:0] c_BYTE_LAST = CW'(BLOCK_BYTES - 1);
  localparam logic [CW-1:0] c_BIT_LAST  = CW'(BLOCK_BYTES * 8 - 1);
`ifdef T05_SD_SCHED_TIMEOUT_EN
  localparam logic [TW-1:0] c_TO_LAST   = TW'(63);
`endif

  logic [DW-1:0] r_div;
  logic          w_tick;
  logic [3:0]    r_state;
  logic [TW-1:0] r_tcnt;
  logic [CW-1:0] r_bcnt;
  logic          r_last_grant_wr;
  logic [6:0]    r_shift;
  logic          w_grant_rd;
  logic          w_grant_wr;

  logic        r_rd_valid, r_rd_last, r_wr_ready, r_wr_done, r_busy;
  logic [7:0]  r_rd_data;
  logic        r_read_en, r_write_en, r_read_stop, r_writebit;
  logic [31:0] r_rd_addr, r_wr_addr;
`ifdef T05_SD_SCHED_TIMEOUT_EN
  logic        r_err;
  assign err = r_err;
`endif

  assign w_tick = (r_div == c_DIV_LAST);
  // Round-robin: on contention the side not served last wins; reset leaves "write" as last.
  assign w_grant_rd = rd_req && (!wr_req || r_last_grant_wr);
  assign w_grant_wr = wr_req && (!rd_req || !r_last_grant_wr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= c_ST_INIT;
      r_tcnt          <= '0;
      r_bcnt          <= '0;
      r_last_grant_wr <= 1'b1;
      r_shift         <= '0;
      r_rd_valid      <= 1'b0;
      r_rd_last       <= 1'b0;
      r_rd_data       <= '0;
      r_wr_ready      <= 1'b0;
      r_wr_done       <= 1'b0;
      r_busy          <= 1'b0;
      r_read_en       <= 1'b0;
      r_write_en      <= 1'b0;
      r_read_stop     <= 1'b0;
      r_writebit      <= 1'b0;
      r_rd_addr       <= '0;
      r_wr_addr       <= '0;
`ifdef T05_SD_SCHED_TIMEOUT_EN
      r_err           <= 1'b0;
`endif
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_wr_ready <= 1'b0;
      r_wr_done  <= 1'b0;
`ifdef T05_SD_SCHED_TIMEOUT_EN
      r_err      <= 1'b0;
`endif
      case (r_state)
        c_ST_INIT: if (w_tick) begin
          if (r_tcnt == c_INIT_LAST) begin
            r_state <= c_ST_IDLE;
            r_tcnt  <= '0;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        c_ST_IDLE: if (w_tick) begin
          r_tcnt <= '0;
          if (w_grant_rd) begin
            r_state         <= c_ST_RDCMD;
            r_rd_addr       <= rd_addr;
            r_read_en       <= 1'b1;
            r_busy          <= 1'b1;
            r_last_grant_wr <= 1'b0;
          end else if (w_grant_wr) begin
            r_state         <= c_ST_WRSW;
            r_wr_addr       <= wr_addr;
            r_write_en      <= 1'b1;
            r_read_stop     <= 1'b1;
            r_busy          <= 1'b1;
            r_last_grant_wr <= 1'b1;
          end
        end
        c_ST_RDCMD: if (w_tick) begin
          if (r_tcnt == c_CMD_LAST) begin
            r_state   <= c_ST_RDSTRM;
            r_read_en <= 1'b0;
            r_tcnt    <= '0;
            r_bcnt    <= '0;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        // 9-tick byte slot: read_en pulses on slot tick 8, byte captured on that same tick.
        c_ST_RDSTRM: if (w_tick) begin
          if (r_tcnt == c_SLOT_LAST) begin
            r_rd_data  <= spi_read_output;
            r_rd_valid <= 1'b1;
            r_rd_last  <= (r_bcnt == c_BYTE_LAST);
            r_read_en  <= 1'b0;
            r_tcnt     <= '0;
            if (r_bcnt == c_BYTE_LAST) begin
              r_state     <= c_ST_RDSTOP;
              r_read_stop <= 1'b1;
            end else begin
              r_bcnt <= r_bcnt + CW'(1);
            end
          end else begin
            r_read_en <= (r_tcnt == c_SLOT_PRE);
            r_tcnt    <= r_tcnt + TW'(1);
          end
        end
        c_ST_RDSTOP: if (w_tick) begin
          if (r_tcnt == c_CMD_LAST) begin
            r_state     <= c_ST_IDLE;
            r_read_stop <= 1'b0;
            r_busy      <= 1'b0;
            r_tcnt      <= '0;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        c_ST_WRSW: if (w_tick) begin
          r_state     <= c_ST_WRCMD;
          r_read_stop <= 1'b0;
          r_tcnt      <= '0;
        end
        c_ST_WRCMD: if (w_tick) begin
          if (r_tcnt == c_CMD_LAST) begin
            r_state    <= c_ST_WRBITS;
            r_shift    <= wr_data[6:0];
            r_writebit <= wr_data[7];
            r_wr_ready <= 1'b1;
            r_bcnt     <= '0;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        c_ST_WRBITS: if (w_tick) begin
          if (r_bcnt == c_BIT_LAST) begin
            r_state    <= c_ST_WREND;
            r_write_en <= 1'b0;
            r_writebit <= 1'b0;
            r_tcnt     <= '0;
          end else begin
            r_bcnt <= r_bcnt + CW'(1);
            if (r_bcnt[2:0] == 3'd7) begin
              r_shift    <= wr_data[6:0];
              r_writebit <= wr_data[7];
              r_wr_ready <= 1'b1;
            end else begin
              r_shift    <= {r_shift[5:0], 1'b0};
              r_writebit <= r_shift[6];
            end
          end
        end
        c_ST_WREND: begin
          if (spi_finish) begin
            r_state   <= c_ST_LOCKED;
            r_wr_done <= 1'b1;
            r_busy    <= 1'b0;
          end
`ifdef T05_SD_SCHED_TIMEOUT_EN
          else if (w_tick) begin
            if (r_tcnt == c_TO_LAST) begin
              r_state <= c_ST_LOCKED;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
`endif
        end
        // The engine cannot leave its DONE state without reset, so neither can we.
        c_ST_LOCKED: r_busy <= 1'b0;
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign spi_serial_clk    = w_tick;
  assign rd_valid          = r_rd_valid;
  assign rd_data           = r_rd_data;
  assign rd_last           = r_rd_last;
  assign wr_ready          = r_wr_ready;
  assign wr_done           = r_wr_done;
  assign busy              = r_busy;
  assign spi_read_en       = r_read_en;
  assign spi_write_en      = r_write_en;
  assign spi_read_stop     = r_read_stop;
  assign spi_writebit      = r_writebit;
  assign spi_read_address  = r_rd_addr;
  assign spi_write_address = r_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_t05_sd_sched.sv
`default_nettype none
// tb_t05_sd_sched: randomized bench; tick-level engine activity expected from transfer-level rules.
module tb_t05_sd_sched;
  localparam int SCLK_DIV    = 4;
  localparam int BLOCK_BYTES = 4;
  localparam int INIT_TICKS  = 16;
  localparam int MAXT        = 1024;
`ifdef T05_SD_SCHED_TIMEOUT_EN
  localparam int NKIND = 4;
`else
  localparam int NKIND = 3;
`endif
  // Per-tick code: {busy, read_en, write_en, read_stop, writebit}
  localparam logic [4:0] c_B  = 5'b10000;
  localparam logic [4:0] c_RE = 5'b01000;
  localparam logic [4:0] c_WE = 5'b00100;
  localparam logic [4:0] c_ST = 5'b00010;

  logic        clk = 1'b0;
  logic        rst, rd_req, wr_req, spi_finish;
  logic [31:0] rd_addr, wr_addr;
  logic [7:0]  wr_data, spi_read_output;
  logic        rd_valid, rd_last, wr_ready, wr_done, busy;
  logic [7:0]  rd_data;
  logic        spi_serial_clk, spi_read_en, spi_write_en, spi_read_stop, spi_writebit;
  logic [31:0] spi_read_address, spi_write_address;
`ifdef T05_SD_SCHED_TIMEOUT_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  t05_sd_sched #(.SCLK_DIV(SCLK_DIV), .BLOCK_BYTES(BLOCK_BYTES), .INIT_TICKS(INIT_TICKS)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done),
`ifdef T05_SD_SCHED_TIMEOUT_EN
    .err(err),
`endif
    .busy(busy), .spi_serial_clk(spi_serial_clk), .spi_read_en(spi_read_en),
    .spi_write_en(spi_write_en), .spi_read_stop(spi_read_stop),
    .spi_read_address(spi_read_address), .spi_write_address(spi_write_address),
    .spi_writebit(spi_writebit), .spi_read_output(spi_read_output), .spi_finish(spi_finish)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]  exp_q[$];
  logic [7:0]  exp_rd[$];
  bit          exp_last[$];
  logic [31:0] exp_raddr[$];
  logic [31:0] rd_addr_list[$];
  logic [7:0]  rdat[MAXT];
  bit          ev_rdaddr[MAXT];
  bit          ev_wraddr[MAXT];
  bit          ev_wrdrop[MAXT];
  bit          ev_lock[MAXT];
  logic [7:0]  wbytes[BLOCK_BYTES];
  logic [31:0] waddr;
  int          fin_tick, abort_tick, rd_pending;
  int          n_wready, n_wdone, n_err, wk;
  int          exp_wdone, exp_err;
  bit          has_wr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_n(input int cnt, input logic [4:0] code);
    for (int i = 0; i < cnt; i++) exp_q.push_back(code);
  endtask

  task automatic model_read(input logic [31:0] a, input bit fixed);
    logic [7:0] fx[4];
    fx = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    ev_rdaddr[exp_q.size()] = 1'b1;
    rd_addr_list.push_back(a);
    exp_raddr.push_back(a);
    push_n(48, c_B | c_RE);
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      push_n(8, c_B);
      if (fixed) rdat[exp_q.size()] = fx[k % 4];
      exp_rd.push_back(rdat[exp_q.size()]);
      exp_last.push_back(k == BLOCK_BYTES - 1);
      exp_q.push_back(c_B | c_RE);
    end
    push_n(48, c_B | c_ST);
    push_n(1, 5'b0);
  endtask

  task automatic model_write(input logic [31:0] a, input int fin_delay, input bit drop);
    has_wr = 1'b1;
    waddr  = a;
    ev_wraddr[exp_q.size()] = 1'b1;
    if (drop) ev_wrdrop[exp_q.size() + 10] = 1'b1;
    push_n(1, c_B | c_WE | c_ST);
    push_n(48, c_B | c_WE);
    for (int k = 0; k < BLOCK_BYTES; k++)
      for (int b = 7; b >= 0; b--)
        exp_q.push_back(c_B | c_WE | 5'(wbytes[k][b]));
    if (fin_delay >= 0) begin
      fin_tick = exp_q.size() + fin_delay;
      push_n(fin_delay + 1, c_B);
      exp_wdone = 1;
    end else begin
      push_n(64, c_B);
      exp_err = 1;
    end
    ev_lock[exp_q.size()] = 1'b1;
    push_n(30, 5'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0; spi_finish = 1'b0;
    spi_read_output = 8'h00; wr_data = 8'h00;
    @(posedge clk); #1;
    check_val("rst_ctl", 32'({rd_valid, rd_last, wr_ready, wr_done, busy, spi_serial_clk,
                              spi_read_en, spi_write_en, spi_read_stop, spi_writebit}), 32'd0);
    check_val("rst_rdata", 32'(rd_data), 32'd0);
    check_val("rst_raddr", spi_read_address, 32'd0);
    check_val("rst_waddr", spi_write_address, 32'd0);
`ifdef T05_SD_SCHED_TIMEOUT_EN
    check_val("rst_err", 32'(err), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_scn(input int kind, input bit fixed);
    int  n, cyc, limit, s2;
    bit  stop, lst;
    logic [7:0]  bexp;
    logic [31:0] aexp;
    exp_q.delete(); exp_rd.delete(); exp_last.delete(); exp_raddr.delete(); rd_addr_list.delete();
    for (int i = 0; i < MAXT; i++) begin
      rdat[i] = 8'($urandom);
      ev_rdaddr[i] = 1'b0; ev_wraddr[i] = 1'b0; ev_wrdrop[i] = 1'b0; ev_lock[i] = 1'b0;
    end
    for (int k = 0; k < BLOCK_BYTES; k++) wbytes[k] = 8'($urandom);
    fin_tick = -1; abort_tick = -1; n_wready = 0; n_wdone = 0; n_err = 0; wk = 0;
    exp_wdone = 0; exp_err = 0; has_wr = 1'b0; rd_pending = 0; waddr = $urandom();
    push_n(INIT_TICKS + 1, 5'b0);
    case (kind)
      0: begin
        if (fixed) begin wbytes[0] = 8'h81; wbytes[1] = 8'h7E; end
        model_read(fixed ? 32'h0000_0010 : $urandom(), fixed);
        model_write($urandom(), int'($urandom_range(0, 10)), 1'b0);
        rd_pending = 1;
      end
      1: begin
        model_read($urandom(), 1'b0);
        s2 = exp_q.size();
        model_read($urandom(), 1'b0);
        abort_tick = s2 + 48 + int'($urandom_range(0, 35));
        rd_pending = 2;
      end
      2: model_write($urandom(), int'($urandom_range(0, 10)), 1'b1);
      default: model_write($urandom(), -1, 1'b0);
    endcase
    do_reset();
    rd_req  = (rd_pending != 0);
    wr_req  = has_wr;
    rd_addr = (rd_addr_list.size() != 0) ? rd_addr_list[0] : $urandom();
    wr_addr = waddr;
    wr_data = wbytes[0];
    n = 0; cyc = 0; stop = 1'b0;
    limit = exp_q.size() * SCLK_DIV + 100;
    while (n < exp_q.size() && !stop) begin
      @(negedge clk);
      cyc++;
      if (cyc > limit) begin
        check_val("cycle_budget", 32'd1, 32'd0);
        break;
      end
      if (rd_valid || wr_ready) check_val("rd_wr_excl", 32'(rd_valid & wr_ready), 32'd0);
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          check_val("rd_extra", 32'd1, 32'd0);
        end else begin
          bexp = exp_rd.pop_front();
          lst  = exp_last.pop_front();
          check_val("rd_data", 32'(rd_data), 32'(bexp));
          check_val("rd_last", 32'(rd_last), 32'(lst));
          if (lst) begin
            aexp = exp_raddr.pop_front();
            check_val("rd_addr", spi_read_address, aexp);
            rd_pending--;
            if (rd_pending == 0) rd_req = 1'b0;
          end
        end
      end
      if (wr_ready) begin
        n_wready++;
        wk++;
        wr_data = (wk < BLOCK_BYTES) ? wbytes[wk] : 8'($urandom);
      end
      if (wr_done) begin
        n_wdone++;
        check_val("wr_addr", spi_write_address, waddr);
        wr_req = 1'b0;
      end
`ifdef T05_SD_SCHED_TIMEOUT_EN
      if (err) begin
        n_err++;
        check_val("err_wr_addr", spi_write_address, waddr);
      end
`endif
      if (spi_serial_clk) begin
        check_val($sformatf("tick%0d", n),
                  32'({busy, spi_read_en, spi_write_en, spi_read_stop, spi_writebit}), 32'(exp_q[n]));
        spi_read_output = rdat[n];
        if (ev_rdaddr[n]) begin
          void'(rd_addr_list.pop_front());
          rd_addr = (rd_addr_list.size() != 0) ? rd_addr_list[0] : $urandom();
        end
        if (ev_wraddr[n]) wr_addr = $urandom();
        if (ev_wrdrop[n]) wr_req = 1'b0;
        if (ev_lock[n]) begin rd_req = 1'b1; wr_req = 1'b1; end
        if (n == fin_tick) spi_finish = 1'b1;
        if (n == abort_tick) stop = 1'b1;
        n++;
      end
    end
    if (!stop) begin
      check_val("rd_left", 32'(exp_rd.size()), 32'd0);
      if (has_wr) begin
        check_val("wr_ready_cnt", 32'(n_wready), 32'(BLOCK_BYTES));
        check_val("wr_done_cnt", 32'(n_wdone), 32'(exp_wdone));
`ifdef T05_SD_SCHED_TIMEOUT_EN
        check_val("err_cnt", 32'(n_err), 32'(exp_err));
`endif
      end
    end
  endtask

  initial begin
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0; spi_finish = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; spi_read_output = '0;
    for (int s = 0; s < 6; s++)
      run_scn((s < NKIND) ? s : int'($urandom_range(0, NKIND - 1)), s == 0);
    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
